// File: rtl/ct_spsram_2048x128_acc_pkg.sv
// Shared sizing and helpers for the 2048x128 single-port SRAM access controller.
package ct_spsram_acc_pkg;

   localparam int ADDR_W    = 11;
   localparam int DATA_W    = 128;
   localparam int BMASK_W   = 16;
   localparam int RSP_DEPTH = 2;
   localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

   typedef enum logic [1:0] {
      GNT_NONE = 2'b00,
      GNT_RD   = 2'b01,
      GNT_WR   = 2'b10
   } gnt_e;

   // Byte enables (1 = write) expanded to the SRAM's active-low per-bit write enables.
   function automatic logic [DATA_W-1:0] bmask_to_wen(input logic [BMASK_W-1:0] bmask);
      logic [DATA_W-1:0] wen;
      for (int i = 0; i < BMASK_W; i++) begin
         wen[8*i +: 8] = {8{~bmask[i]}};
      end
      return wen;
   endfunction

endpackage

// File: rtl/ct_spsram_2048x128_acc_if.sv
// Request/response bus of the SRAM access controller: write, read and read-response channels.
interface ct_spsram_2048x128_acc_if;
   import ct_spsram_acc_pkg::*;

   logic                wr_vld;
   logic                wr_rdy;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic [BMASK_W-1:0]  wr_bmask;

   logic                rd_vld;
   logic                rd_rdy;
   logic [ADDR_W-1:0]   rd_addr;

   logic                rsp_vld;
   logic                rsp_rdy;
   logic [DATA_W-1:0]   rsp_data;

   modport master (
      output wr_vld, wr_addr, wr_data, wr_bmask, rd_vld, rd_addr, rsp_rdy,
      input  wr_rdy, rd_rdy, rsp_vld, rsp_data
   );

   modport slave (
      input  wr_vld, wr_addr, wr_data, wr_bmask, rd_vld, rd_addr, rsp_rdy,
      output wr_rdy, rd_rdy, rsp_vld, rsp_data
   );

endinterface

// File: rtl/ct_spsram_acc_rsp_fifo.sv
// Small synchronous FIFO holding captured read data until the requester takes it.
module ct_spsram_acc_rsp_fifo #(
   parameter int  DEPTH = 2,
   parameter int  WIDTH = 128,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/ct_spsram_2048x128_acc.sv
// Read/write arbiter and response buffering in front of a 2048x128 single-port SRAM.
// Define CT_SPSRAM_ACC_RR_ARB_EN for round-robin read/write arbitration; default is read priority.
module ct_spsram_2048x128_acc
   import ct_spsram_acc_pkg::*;
(
   input  logic                   CLK,
   input  logic                   RST,
   ct_spsram_2048x128_acc_if.slave bus,
   output logic [ADDR_W-1:0]      sram_A,
   output logic                   sram_CEN,
   output logic                   sram_GWEN,
   output logic [DATA_W-1:0]      sram_WEN,
   output logic [DATA_W-1:0]      sram_D,
   input  logic [DATA_W-1:0]      sram_Q
);

   localparam logic [CNT_W:0] DEPTH_LD = RSP_DEPTH[CNT_W:0];

   gnt_e             gnt;
   logic             rd_fire;
   logic             wr_fire;
   logic             rd_elig;
   logic             rd_credit;
   logic             rd_vld_p1;
   logic             pop;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   load;

   // Counting a same-cycle pop as returned credit keeps reads at one per cycle.
   assign pop       = ~RST & ~empty & bus.rsp_rdy;
   assign load      = {1'b0, count} + {{CNT_W{1'b0}}, rd_vld_p1};
   assign rd_credit = pop | (~full & (load < DEPTH_LD));
   assign rd_elig   = bus.rd_vld & rd_credit;

`ifdef CT_SPSRAM_ACC_RR_ARB_EN
   logic last_wr;

   always_ff @(posedge CLK) begin
      if (RST)          last_wr <= 1'b1;
      else if (rd_fire) last_wr <= 1'b0;
      else if (wr_fire) last_wr <= 1'b1;
   end

   always_comb begin
      gnt = GNT_NONE;
      if (!RST) begin
         if (rd_elig && bus.wr_vld) gnt = last_wr ? GNT_RD : GNT_WR;
         else if (rd_elig)          gnt = GNT_RD;
         else if (bus.wr_vld)       gnt = GNT_WR;
      end
   end
`else
   always_comb begin
      gnt = GNT_NONE;
      if (!RST) begin
         if (rd_elig)         gnt = GNT_RD;
         else if (bus.wr_vld) gnt = GNT_WR;
      end
   end
`endif

   assign rd_fire    = (gnt == GNT_RD);
   assign wr_fire    = (gnt == GNT_WR);
   assign bus.rd_rdy = rd_fire;
   assign bus.wr_rdy = wr_fire;

   // An all-zero byte mask is accepted but leaves the macro deselected.
   always_comb begin
      sram_A    = '0;
      sram_D    = '0;
      sram_CEN  = 1'b1;
      sram_GWEN = 1'b1;
      sram_WEN  = '1;
      if (rd_fire) begin
         sram_A   = bus.rd_addr;
         sram_CEN = 1'b0;
      end else if (wr_fire) begin
         sram_A    = bus.wr_addr;
         sram_D    = bus.wr_data;
         sram_GWEN = 1'b0;
         sram_CEN  = ~(|bus.wr_bmask);
         sram_WEN  = bmask_to_wen(bus.wr_bmask);
      end
   end

   // p0 -> p1: read issued to the SRAM, data appears on sram_Q one cycle later
   always_ff @(posedge CLK) begin
      if (RST) rd_vld_p1 <= 1'b0;
      else     rd_vld_p1 <= rd_fire;
   end

   ct_spsram_acc_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (DATA_W)
   ) u_rsp_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (rd_vld_p1),
      .pop   (pop),
      .din   (sram_Q),
      .dout  (bus.rsp_data),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign bus.rsp_vld = ~RST & ~empty;

endmodule

// File: doc/ct_spsram_2048x128_acc.md
CT_SPSRAM_2048X128_ACC -- requirements
Module: ct_spsram_2048x128_acc

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset. Ports are named CLK and RST.
REQ-002 CLK  input  1  rising-edge clock, shared with the attached 2048x128 SRAM.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 wr_vld / wr_rdy  in / out  1 / 1  write request handshake.
REQ-005 wr_addr  in  11  write word address. wr_data  in  128  write data.
REQ-006 wr_bmask  in  16  byte enables, 1 = write the byte.
REQ-007 rd_vld / rd_rdy  in / out  1 / 1  read request handshake. rd_addr  in  11  read word address.
REQ-008 rsp_vld / rsp_rdy  out / in  1 / 1  read response handshake. rsp_data  out  128  read response data.
REQ-009 sram_A (out, 11), sram_CEN (out, 1, active-low), sram_GWEN (out, 1, low = write), sram_WEN (out, 128, per-bit, low = write), sram_D (out, 128) drive the SRAM.
REQ-010 sram_Q  in  128  SRAM read data; valid 1 cycle after a read access.

Function
REQ-011 A read fires when rd_vld & rd_rdy. A write fires when wr_vld & wr_rdy. At most one fires per cycle.
REQ-012 SRAM outputs are combinational from the firing request:
- sram_CEN = 0 on any fire, else 1.
- sram_GWEN = 0 only on a write fire.
REQ-013 sram_WEN[8i+7:8i] = ~{8{wr_bmask[i]}} on a write fire; all ones otherwise.
REQ-014 sram_A and sram_D carry the firing request's address and data. When idle they hold 0.
REQ-015 A write fire with wr_bmask == 0 is accepted (wr_rdy = 1) but keeps sram_CEN = 1.
REQ-016 Read data is captured from sram_Q exactly 1 cycle after the read fire, into a 2-entry response FIFO.
REQ-017 rsp_vld = FIFO not empty. rsp_data = FIFO head. The head pops on rsp_vld & rsp_rdy.
REQ-018 Credit = 2 − (FIFO occupancy + in-flight read). A read is eligible only when credit > 0. There is no response loss and no overflow.
REQ-019 Back-to-back reads SHALL sustain 1 per cycle while rsp_rdy = 1.
REQ-020 Simultaneous push and pop on a full FIFO is legal. Occupancy stays constant.
REQ-021 Arbitration default: fixed priority, reads first. A write is granted only when rd_vld = 0 or read credit = 0.
REQ-022 rd_rdy and wr_rdy SHALL be asserted only for the granted requester. Neither depends on its own vld input being unchanged later.
REQ-023 A write in cycle N followed by a read of the same address in cycle N+1 SHALL return the new data.
REQ-024 A write and a read to the same address in the same cycle resolve in grant order.

Reset
REQ-025 While RST = 1: wr_rdy = 0, rd_rdy = 0, rsp_vld = 0, sram_CEN = 1, sram_GWEN = 1, sram_WEN all ones, sram_A = 0, sram_D = 0.
REQ-026 RST also clears FIFO pointers, occupancy, the in-flight flag and the arbiter state.
REQ-027 A read in flight when RST asserts is discarded, and no rsp_vld follows.
REQ-028 The first fire is possible in the first cycle after RST deasserts.

Configuration
REQ-029 Macro CT_SPSRAM_ACC_RR_ARB_EN selects the arbitration policy.
- Defined: round-robin between read and write. A last-granted flag toggles on each fire. Under continuous contention, grants alternate R,W,R,W (reads first after reset).
- Undefined: the fixed read-priority policy of REQ-021.

Structure
REQ-030 Package ct_spsram_acc_pkg SHALL hold ADDR_W = 11, DATA_W = 128, BMASK_W = 16 and RSP_DEPTH = 2.
REQ-031 The response FIFO is a sub-module, ct_spsram_acc_rsp_fifo (parameterised depth/width, push/pop/full/empty/count).

Verification
REQ-032 Write 0x7F0 with data 0x0123..EF and bmask 0xFFFF, then read 0x7F0 next cycle -> rsp_vld 2 cycles after the read fire, with rsp_data = 0x0123..EF.
REQ-033 Write 0x005 with bmask 0x0001 and data all-0xAA over prior all-0x55 -> read returns byte0 = 0xAA and the rest 0x55. Write with bmask 0 -> sram_CEN stays 1.
REQ-034 Hold rsp_rdy = 0 and issue 4 reads -> exactly 2 accepted, then rd_rdy = 0. Raise rsp_rdy -> data returns in order, and the remaining reads then proceed.
REQ-035 rd_vld = wr_vld = 1 continuously for 6 cycles:
- without the macro: 6 read grants, 0 write grants;
- with the macro: grant order R,W,R,W,R,W.
REQ-036 Assert RST in the cycle after a read fire -> no rsp_vld ever appears for that read, and all outputs take their reset values the next cycle.
